// File: rtl/mvb_last_vld_chan_pkg.sv
// Shared constants, implementation selector and a behavioural lookup reference
// for the per-channel MVB last-valid block (default geometry).
package mvb_last_vld_chan_pkg;

    localparam int DEF_ITEMS      = 4;
    localparam int DEF_ITEM_WIDTH = 8;
    localparam int DEF_CHANNELS   = 4;
    localparam int CHAN_W         = $clog2(DEF_CHANNELS);

    typedef enum logic [0:0] {
        SERIAL = 1'b0,
        PREFIX = 1'b1
    } impl_e;

    // Newest matching valid item at or below i wins, else the stored channel value.
    function automatic void lookup_ref(
        input  logic [DEF_ITEMS*DEF_ITEM_WIDTH-1:0]    data,
        input  logic [DEF_ITEMS*CHAN_W-1:0]            chan,
        input  logic [DEF_ITEMS-1:0]                   vld,
        input  logic [DEF_CHANNELS*DEF_ITEM_WIDTH-1:0] st_data,
        input  logic [DEF_CHANNELS-1:0]                st_flag,
        output logic [DEF_ITEMS*DEF_ITEM_WIDTH-1:0]    lk_data,
        output logic [DEF_ITEMS-1:0]                   lk_present
    );
        int c;
        bit found;
        lk_data    = '0;
        lk_present = '0;
        for (int i = 0; i < DEF_ITEMS; i++) begin
            c     = int'(chan[i*CHAN_W +: CHAN_W]);
            found = 1'b0;
            if (c < DEF_CHANNELS) begin
                for (int j = i; j >= 0; j--) begin
                    if (!found && vld[j] && int'(chan[j*CHAN_W +: CHAN_W]) == c) begin
                        lk_data[i*DEF_ITEM_WIDTH +: DEF_ITEM_WIDTH] = data[j*DEF_ITEM_WIDTH +: DEF_ITEM_WIDTH];
                        lk_present[i] = 1'b1;
                        found         = 1'b1;
                    end
                end
                if (!found) begin
                    lk_data[i*DEF_ITEM_WIDTH +: DEF_ITEM_WIDTH] = st_data[c*DEF_ITEM_WIDTH +: DEF_ITEM_WIDTH];
                    lk_present[i] = st_flag[c];
                end
            end
        end
    endfunction

endpackage

// File: rtl/mvb_last_vld_chan_select.sv
// Combinational per-item match/select network: per-item lookup of the newest
// value of its channel and per-channel update data for the register file.
module mvb_last_vld_chan_select
    import mvb_last_vld_chan_pkg::*;
#(
    parameter int    ITEMS      = 4,
    parameter int    ITEM_WIDTH = 8,
    parameter int    CHANNELS   = 4,
    parameter int    CW         = 2,
    parameter impl_e IMPL       = SERIAL
) (
    input  logic [ITEMS*ITEM_WIDTH-1:0]    rx_data,
    input  logic [ITEMS*CW-1:0]            rx_chan,
    input  logic [ITEMS-1:0]               rx_vld,
    input  logic [CHANNELS*ITEM_WIDTH-1:0] st_data,
    input  logic [CHANNELS-1:0]            st_flag,
    output logic [ITEMS*ITEM_WIDTH-1:0]    lk_data,
    output logic [ITEMS-1:0]               lk_present,
    output logic [CHANNELS*ITEM_WIDTH-1:0] upd_data,
    output logic [CHANNELS-1:0]            upd_vld
);

    logic [ITEM_WIDTH-1:0] d    [ITEMS];
    logic [CW-1:0]         ch   [ITEMS];
    logic                  ch_ok[ITEMS];
    logic [ITEM_WIDTH-1:0] sd   [CHANNELS];
    logic [CHANNELS-1:0]   hit  [ITEMS];

    for (genvar j = 0; j < ITEMS; j++) begin : g_unpack_item
        assign d[j]     = rx_data[j*ITEM_WIDTH +: ITEM_WIDTH];
        assign ch[j]    = rx_chan[j*CW +: CW];
        assign ch_ok[j] = ({1'b0, ch[j]} < (CW+1)'(CHANNELS));
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_unpack_chan
        assign sd[k] = st_data[k*ITEM_WIDTH +: ITEM_WIDTH];
    end

    // Out-of-range channel indices never match any tracked channel.
    always_comb begin
        for (int j = 0; j < ITEMS; j++) begin
            hit[j] = '0;
            for (int k = 0; k < CHANNELS; k++) begin
                hit[j][k] = rx_vld[j] && (ch[j] == CW'(k));
            end
        end
    end

    if (IMPL == SERIAL) begin : g_serial
        always_comb begin
            lk_data    = '0;
            lk_present = '0;
            for (int i = 0; i < ITEMS; i++) begin
                if (ch_ok[i]) begin
                    lk_data[i*ITEM_WIDTH +: ITEM_WIDTH] = sd[ch[i]];
                    lk_present[i] = st_flag[ch[i]];
                    for (int j = 0; j <= i; j++) begin
                        if (rx_vld[j] && ch[j] == ch[i]) begin
                            lk_data[i*ITEM_WIDTH +: ITEM_WIDTH] = d[j];
                            lk_present[i] = 1'b1;
                        end
                    end
                end
            end
        end

        always_comb begin
            upd_data = '0;
            upd_vld  = '0;
            for (int k = 0; k < CHANNELS; k++) begin
                for (int j = 0; j < ITEMS; j++) begin
                    if (hit[j][k]) begin
                        upd_data[k*ITEM_WIDTH +: ITEM_WIDTH] = d[j];
                        upd_vld[k] = 1'b1;
                    end
                end
            end
        end
    end else begin : g_prefix
        localparam int LVLS = $clog2(ITEMS);

        // Kogge-Stone scan per channel; the right-hand (newer) valid operand wins.
        logic [ITEMS-1:0]      pv [LVLS+1][CHANNELS];
        logic [ITEM_WIDTH-1:0] pd [LVLS+1][CHANNELS][ITEMS];

        always_comb begin
            int src;
            for (int k = 0; k < CHANNELS; k++) begin
                for (int j = 0; j < ITEMS; j++) begin
                    pv[0][k][j] = hit[j][k];
                    pd[0][k][j] = hit[j][k] ? d[j] : '0;
                end
            end
            for (int l = 0; l < LVLS; l++) begin
                for (int k = 0; k < CHANNELS; k++) begin
                    for (int j = 0; j < ITEMS; j++) begin
                        src = (j >= (1 << l)) ? j - (1 << l) : j;
                        if (j >= (1 << l) && !pv[l][k][j]) begin
                            pv[l+1][k][j] = pv[l][k][src];
                            pd[l+1][k][j] = pd[l][k][src];
                        end else begin
                            pv[l+1][k][j] = pv[l][k][j];
                            pd[l+1][k][j] = pd[l][k][j];
                        end
                    end
                end
            end
        end

        always_comb begin
            lk_data    = '0;
            lk_present = '0;
            for (int i = 0; i < ITEMS; i++) begin
                if (ch_ok[i]) begin
                    if (pv[LVLS][ch[i]][i]) begin
                        lk_data[i*ITEM_WIDTH +: ITEM_WIDTH] = pd[LVLS][ch[i]][i];
                        lk_present[i] = 1'b1;
                    end else begin
                        lk_data[i*ITEM_WIDTH +: ITEM_WIDTH] = sd[ch[i]];
                        lk_present[i] = st_flag[ch[i]];
                    end
                end
            end
        end

        always_comb begin
            upd_data = '0;
            upd_vld  = '0;
            for (int k = 0; k < CHANNELS; k++) begin
                upd_vld[k] = pv[LVLS][k][ITEMS-1];
                upd_data[k*ITEM_WIDTH +: ITEM_WIDTH] = pd[LVLS][k][ITEMS-1];
            end
        end
    end

endmodule

// File: rtl/mvb_last_vld_chan.sv
// Per-channel MVB last-valid aggregator: channel register file, clear logic
// and the one-stage output register around the select network.
module mvb_last_vld_chan
    import mvb_last_vld_chan_pkg::*;
#(
    parameter int    ITEMS          = 4,
    parameter int    ITEM_WIDTH     = 8,
    parameter int    CHANNELS       = 4,
    parameter string IMPLEMENTATION = "serial",
    localparam int   CW             = $clog2(CHANNELS)
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [ITEMS*ITEM_WIDTH-1:0] RX_DATA,
    input  logic [ITEMS*CW-1:0]         RX_CHAN,
    input  logic [ITEMS-1:0]            RX_VLD,
    input  logic                        RX_SRC_RDY,
    output logic                        RX_DST_RDY,
    output logic [ITEMS*ITEM_WIDTH-1:0] TX_DATA,
    output logic [ITEMS-1:0]            TX_PRESENT,
    output logic [ITEMS-1:0]            TX_VLD,
    output logic                        TX_SRC_RDY,
    input  logic                        TX_DST_RDY,
    input  logic [CW-1:0]               CLR_CHAN,
    input  logic                        CLR_VLD
);

    localparam impl_e IMPL = (IMPLEMENTATION == "prefix") ? PREFIX : SERIAL;

    logic [CHANNELS*ITEM_WIDTH-1:0] st_data_q;
    logic [CHANNELS-1:0]            st_flag_q;
    logic [ITEMS*ITEM_WIDTH-1:0]    lk_data;
    logic [ITEMS-1:0]               lk_present;
    logic [CHANNELS*ITEM_WIDTH-1:0] upd_data;
    logic [CHANNELS-1:0]            upd_vld;
    logic                           accept;

    assign RX_DST_RDY = TX_DST_RDY || !TX_SRC_RDY;
    assign accept     = RX_SRC_RDY && RX_DST_RDY;

    mvb_last_vld_chan_select #(
        .ITEMS      (ITEMS),
        .ITEM_WIDTH (ITEM_WIDTH),
        .CHANNELS   (CHANNELS),
        .CW         (CW),
        .IMPL       (IMPL)
    ) u_select (
        .rx_data    (RX_DATA),
        .rx_chan    (RX_CHAN),
        .rx_vld     (RX_VLD),
        .st_data    (st_data_q),
        .st_flag    (st_flag_q),
        .lk_data    (lk_data),
        .lk_present (lk_present),
        .upd_data   (upd_data),
        .upd_vld    (upd_vld)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            TX_SRC_RDY <= 1'b0;
            TX_DATA    <= '0;
            TX_PRESENT <= '0;
            TX_VLD     <= '0;
        end else if (accept) begin
            TX_SRC_RDY <= 1'b1;
            TX_DATA    <= lk_data;
            TX_PRESENT <= lk_present;
            TX_VLD     <= RX_VLD;
        end else if (TX_DST_RDY) begin
            TX_SRC_RDY <= 1'b0;
        end
    end

    // A same-cycle word update of the cleared channel takes priority: it is newer data.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            st_data_q <= '0;
            st_flag_q <= '0;
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (accept && upd_vld[k]) begin
                    st_data_q[k*ITEM_WIDTH +: ITEM_WIDTH] <= upd_data[k*ITEM_WIDTH +: ITEM_WIDTH];
                    st_flag_q[k] <= 1'b1;
                end else if (CLR_VLD && CLR_CHAN == CW'(k)) begin
                    st_flag_q[k] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mvb_last_vld_chan.sv
// Directed and randomised checks of mvb_last_vld_chan, serial and prefix builds side by side.
module tb_mvb_last_vld_chan;
    import mvb_last_vld_chan_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] RX_DATA;
    logic [7:0]  RX_CHAN;
    logic [3:0]  RX_VLD;
    logic        RX_SRC_RDY;
    logic        TX_DST_RDY;
    logic [1:0]  CLR_CHAN;
    logic        CLR_VLD;

    logic        s_rx_dst_rdy, p_rx_dst_rdy;
    logic [31:0] s_tx_data, p_tx_data;
    logic [3:0]  s_tx_present, p_tx_present;
    logic [3:0]  s_tx_vld, p_tx_vld;
    logic        s_tx_src_rdy, p_tx_src_rdy;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    mvb_last_vld_chan #(.ITEMS(4), .ITEM_WIDTH(8), .CHANNELS(4), .IMPLEMENTATION("serial")) u_ser (
        .CLK(CLK), .RESET(RESET), .RX_DATA(RX_DATA), .RX_CHAN(RX_CHAN), .RX_VLD(RX_VLD),
        .RX_SRC_RDY(RX_SRC_RDY), .RX_DST_RDY(s_rx_dst_rdy), .TX_DATA(s_tx_data),
        .TX_PRESENT(s_tx_present), .TX_VLD(s_tx_vld), .TX_SRC_RDY(s_tx_src_rdy),
        .TX_DST_RDY(TX_DST_RDY), .CLR_CHAN(CLR_CHAN), .CLR_VLD(CLR_VLD)
    );

    mvb_last_vld_chan #(.ITEMS(4), .ITEM_WIDTH(8), .CHANNELS(4), .IMPLEMENTATION("prefix")) u_pre (
        .CLK(CLK), .RESET(RESET), .RX_DATA(RX_DATA), .RX_CHAN(RX_CHAN), .RX_VLD(RX_VLD),
        .RX_SRC_RDY(RX_SRC_RDY), .RX_DST_RDY(p_rx_dst_rdy), .TX_DATA(p_tx_data),
        .TX_PRESENT(p_tx_present), .TX_VLD(p_tx_vld), .TX_SRC_RDY(p_tx_src_rdy),
        .TX_DST_RDY(TX_DST_RDY), .CLR_CHAN(CLR_CHAN), .CLR_VLD(CLR_VLD)
    );

    // Drive one cycle of stimulus at a falling edge; return at the next falling edge.
    task automatic xfer(input logic [7:0] ch, input logic [31:0] dat, input logic [3:0] v,
                        input logic src, input logic cv, input logic [1:0] cc);
        RX_CHAN = ch; RX_DATA = dat; RX_VLD = v; RX_SRC_RDY = src; CLR_VLD = cv; CLR_CHAN = cc;
        @(negedge CLK);
        RX_SRC_RDY = 1'b0; CLR_VLD = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1; RX_DATA = '0; RX_CHAN = '0; RX_VLD = '0; RX_SRC_RDY = 1'b0;
        TX_DST_RDY = 1'b1; CLR_CHAN = '0; CLR_VLD = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if ({s_tx_src_rdy, s_tx_vld, s_tx_present, s_tx_data} !== 41'd0) begin
            errors++; $display("FAIL reset_ser got %h exp 0", {s_tx_src_rdy, s_tx_vld, s_tx_present, s_tx_data});
        end
        checks++;
        if ({p_tx_src_rdy, p_tx_vld, p_tx_present, p_tx_data} !== 41'd0) begin
            errors++; $display("FAIL reset_pre got %h exp 0", {p_tx_src_rdy, p_tx_vld, p_tx_present, p_tx_data});
        end
        checks++;
        if (s_rx_dst_rdy !== 1'b1) begin errors++; $display("FAIL reset_dst_rdy got %b exp 1", s_rx_dst_rdy); end
        RESET = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_basic();
        xfer(8'b10_00_01_00, 32'h44332211, 4'b1011, 1'b1, 1'b0, 2'd0);
        checks++;
        if (s_tx_data !== 32'h44112211) begin errors++; $display("FAIL t1_data got %h exp 44112211", s_tx_data); end
        checks++;
        if ({s_tx_src_rdy, s_tx_present, s_tx_vld} !== 9'b1_1111_1011) begin
            errors++; $display("FAIL t1_flags got %b exp 111111011", {s_tx_src_rdy, s_tx_present, s_tx_vld});
        end
        xfer(8'hAA, 32'h0, 4'b0000, 1'b1, 1'b0, 2'd0);
        checks++;
        if ({s_tx_present, s_tx_data} !== {4'b1111, 32'h44444444}) begin
            errors++; $display("FAIL t2_lookup got %b %h exp 1111 44444444", s_tx_present, s_tx_data);
        end
        xfer(8'hFF, 32'h00550000, 4'b0100, 1'b1, 1'b0, 2'd0);
        checks++;
        if ({s_tx_present, s_tx_data} !== {4'b1100, 32'h55550000}) begin
            errors++; $display("FAIL t3_lookup got %b %h exp 1100 55550000", s_tx_present, s_tx_data);
        end
    endtask

    task automatic test_clear();
        xfer(8'h00, 32'h0, 4'b0000, 1'b0, 1'b1, 2'd0);
        xfer(8'h00, 32'h0, 4'b0000, 1'b1, 1'b0, 2'd0);
        checks++;
        if ({s_tx_present, s_tx_data} !== {4'b0000, 32'h11111111}) begin
            errors++; $display("FAIL clr_idle got %b %h exp 0000 11111111", s_tx_present, s_tx_data);
        end
        xfer(8'h55, 32'h00000066, 4'b0001, 1'b1, 1'b1, 2'd1);
        checks++;
        if ({s_tx_present, s_tx_data} !== {4'b1111, 32'h66666666}) begin
            errors++; $display("FAIL clr_same_word got %b %h exp 1111 66666666", s_tx_present, s_tx_data);
        end
        xfer(8'h55, 32'h0, 4'b0000, 1'b1, 1'b0, 2'd0);
        checks++;
        if ({s_tx_present, s_tx_data} !== {4'b1111, 32'h66666666}) begin
            errors++; $display("FAIL clr_update_wins got %b %h exp 1111 66666666", s_tx_present, s_tx_data);
        end
        xfer(8'hAA, 32'h0, 4'b0000, 1'b1, 1'b1, 2'd2);
        checks++;
        if ({s_tx_present, s_tx_data} !== {4'b1111, 32'h44444444}) begin
            errors++; $display("FAIL clr_old_state got %b %h exp 1111 44444444", s_tx_present, s_tx_data);
        end
        xfer(8'hAA, 32'h0, 4'b0000, 1'b1, 1'b0, 2'd0);
        checks++;
        if ({s_tx_present, s_tx_data} !== {4'b0000, 32'h44444444}) begin
            errors++; $display("FAIL clr_applied got %b %h exp 0000 44444444", s_tx_present, s_tx_data);
        end
    endtask

    task automatic test_stall();
        xfer(8'h00, 32'h04030201, 4'b1111, 1'b1, 1'b0, 2'd0);
        checks++;
        if (s_tx_data !== 32'h04030201) begin errors++; $display("FAIL stall_first got %h exp 04030201", s_tx_data); end
        TX_DST_RDY = 1'b0; RX_CHAN = 8'h00; RX_DATA = 32'h00000077; RX_VLD = 4'b0001; RX_SRC_RDY = 1'b1;
        for (int n = 0; n < 5; n++) begin
            #1;
            checks++;
            if (s_rx_dst_rdy !== 1'b0 || p_rx_dst_rdy !== 1'b0) begin
                errors++; $display("FAIL stall_dst_rdy cyc %0d got %b%b exp 00", n, s_rx_dst_rdy, p_rx_dst_rdy);
            end
            checks++;
            if ({s_tx_src_rdy, s_tx_data} !== {1'b1, 32'h04030201}) begin
                errors++; $display("FAIL stall_hold cyc %0d got %b %h exp 1 04030201", n, s_tx_src_rdy, s_tx_data);
            end
            @(negedge CLK);
        end
        TX_DST_RDY = 1'b1;
        @(negedge CLK);
        RX_SRC_RDY = 1'b0;
        checks++;
        if ({s_tx_src_rdy, s_tx_present, s_tx_data} !== {1'b1, 4'b1111, 32'h77777777}) begin
            errors++; $display("FAIL stall_release got %b %b %h exp 1 1111 77777777", s_tx_src_rdy, s_tx_present, s_tx_data);
        end
        @(negedge CLK);
        checks++;
        if (s_tx_src_rdy !== 1'b0) begin errors++; $display("FAIL stall_no_dup got %b exp 0", s_tx_src_rdy); end
    endtask

    task automatic test_reset_midstream();
        xfer(8'h00, 32'h0A0B0C0D, 4'b1111, 1'b1, 1'b0, 2'd0);
        TX_DST_RDY = 1'b0; RESET = 1'b1;
        @(negedge CLK);
        checks++;
        if ({s_tx_src_rdy, p_tx_src_rdy, s_tx_present, s_tx_data} !== 38'd0) begin
            errors++; $display("FAIL rst_mid_drop got %b%b %b %h exp 00 0000 0", s_tx_src_rdy, p_tx_src_rdy, s_tx_present, s_tx_data);
        end
        RESET = 1'b0; TX_DST_RDY = 1'b1;
        xfer(8'h00, 32'h0, 4'b0000, 1'b1, 1'b0, 2'd0);
        checks++;
        if ({s_tx_present, s_tx_data} !== {4'b0000, 32'h0}) begin
            errors++; $display("FAIL rst_mid_state got %b %h exp 0000 0", s_tx_present, s_tx_data);
        end
    endtask

    task automatic test_random();
        logic [31:0] m_data;
        logic [3:0]  m_flag;
        logic        e_src, e_dst, acc;
        logic [31:0] e_data, ld;
        logic [3:0]  e_pres, e_vld, lp;
        logic [1:0]  c;
        int words, cyc;
        RESET = 1'b1; RX_SRC_RDY = 1'b0; CLR_VLD = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        m_data = '0; m_flag = '0; e_src = 1'b0; e_data = '0; e_pres = '0; e_vld = '0;
        words = 0; cyc = 0;
        while (words < 10000 && cyc < 40000) begin
            checks++;
            if ({s_tx_src_rdy, s_tx_vld, s_tx_present, s_tx_data} !== {e_src, e_vld, e_pres, e_data}) begin
                errors++; $display("FAIL rand_ser cyc %0d got %h exp %h", cyc,
                    {s_tx_src_rdy, s_tx_vld, s_tx_present, s_tx_data}, {e_src, e_vld, e_pres, e_data});
            end
            checks++;
            if ({p_tx_src_rdy, p_tx_vld, p_tx_present, p_tx_data} !== {e_src, e_vld, e_pres, e_data}) begin
                errors++; $display("FAIL rand_pre cyc %0d got %h exp %h", cyc,
                    {p_tx_src_rdy, p_tx_vld, p_tx_present, p_tx_data}, {e_src, e_vld, e_pres, e_data});
            end
            RX_SRC_RDY = ($urandom_range(0, 3) != 0);
            TX_DST_RDY = ($urandom_range(0, 3) != 0);
            CLR_VLD    = ($urandom_range(0, 5) == 0);
            CLR_CHAN   = 2'($urandom);
            RX_CHAN    = 8'($urandom);
            RX_DATA    = $urandom;
            RX_VLD     = 4'($urandom);
            e_dst = TX_DST_RDY || !e_src;
            acc   = RX_SRC_RDY && e_dst;
            #1;
            checks++;
            if (s_rx_dst_rdy !== e_dst || p_rx_dst_rdy !== e_dst) begin
                errors++; $display("FAIL rand_dst_rdy cyc %0d got %b%b exp %b", cyc, s_rx_dst_rdy, p_rx_dst_rdy, e_dst);
            end
            lookup_ref(RX_DATA, RX_CHAN, RX_VLD, m_data, m_flag, ld, lp);
            if (acc) begin
                e_src = 1'b1; e_data = ld; e_pres = lp; e_vld = RX_VLD; words++;
            end else if (TX_DST_RDY) begin
                e_src = 1'b0;
            end
            if (CLR_VLD) m_flag[CLR_CHAN] = 1'b0;
            if (acc) begin
                for (int j = 0; j < 4; j++) begin
                    if (RX_VLD[j]) begin
                        c = RX_CHAN[j*2 +: 2];
                        m_data[c*8 +: 8] = RX_DATA[j*8 +: 8];
                        m_flag[c] = 1'b1;
                    end
                end
            end
            @(negedge CLK);
            cyc++;
        end
        RX_SRC_RDY = 1'b0; CLR_VLD = 1'b0; TX_DST_RDY = 1'b1;
        checks++;
        if (words < 10000) begin errors++; $display("FAIL rand_budget words %0d exp 10000", words); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clear();
        test_stall();
        test_reset_midstream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
